ro_capture: RTL and testbench

RO_CAPTURE -- requirements
Module: ro_capture

---
 rtl/ro_pkg.sv | 19 +
 rtl/ro_fifo.sv | 52 +++++
 rtl/ro_capture.sv | 110 +++++++++++
 tb/tb_ro_capture.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ro_pkg.sv
// Shared types and constants for the readout event capture block.
package ro_pkg;

  localparam int NCORE_DEF = 19;
  localparam int CORE_ID_W = 5;
  localparam int EV_W      = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } ro_state_e;

  typedef struct packed {
    logic [CORE_ID_W-1:0] core_id;
    logic                 pol;
  } ev_word;

endpackage

// File: rtl/ro_fifo.sv
// Synchronous FIFO with wrap-bit pointers; read data is combinational from the head
// and forced to zero while empty so the output is clean after reset.
module ro_fifo #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    do_push = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ro_capture.sv
// Gray-slot readout capture: a single-bit gray transition selects the core whose
// bus event is queued; multi-bit transitions raise a sticky error.
module ro_capture
  import ro_pkg::*;
#(
  parameter int NCORE = NCORE_DEF,
  parameter int DEPTH = 8
) (
  input  logic             clk_master,
  input  logic             rst,
  input  logic             en,
  input  logic [NCORE-1:0] gray,
  input  logic             bus_eve,
  input  logic             bus_pol_eve,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [EV_W-1:0]  ev_data,
  output logic [7:0]       drop_cnt,
  output logic             gray_err
);

  localparam int CNT_W = $clog2(NCORE + 1);

  function automatic logic [CNT_W-1:0] popcount(input logic [NCORE-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NCORE; i++) cnt = cnt + CNT_W'(v[i]);
    return cnt;
  endfunction

  function automatic logic [CORE_ID_W-1:0] onehot_idx(input logic [NCORE-1:0] v);
    logic [CORE_ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NCORE; i++) if (v[i]) idx = CORE_ID_W'(i);
    return idx;
  endfunction

  ro_state_e        state_q, state_d;
  logic [NCORE-1:0] gray_q, gray_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             gray_err_q, gray_err_d;

  logic [NCORE-1:0] diff;
  logic [CNT_W-1:0] pc;
  logic             cmp_en, slot_valid, push, pop, drop;
  logic             fifo_full, fifo_empty;
  ev_word           wword;

  always_comb begin
    state_d    = state_q;
    gray_d     = gray;
    drop_cnt_d = drop_cnt_q;
    gray_err_d = gray_err_q;

    diff       = gray ^ gray_q;
    pc         = popcount(diff);
    cmp_en     = (state_q == RUN) && en;
    slot_valid = cmp_en && (pc == CNT_W'(1));
    push       = slot_valid && bus_eve;
    wword.core_id = onehot_idx(diff);
    wword.pol     = bus_pol_eve;

    pop  = ev_valid && ev_ready;
    drop = push && fifo_full && !pop;

    if (cmp_en && (pc > CNT_W'(1))) gray_err_d = 1'b1;
    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;

    // PRIME spends one edge refreshing gray_q so the first RUN compare is never stale.
    unique case (state_q)
      IDLE:    if (en) state_d = PRIME;
      PRIME:   state_d = RUN;
      RUN:     if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_master) begin
    if (rst) begin
      state_q    <= IDLE;
      gray_q     <= '0;
      drop_cnt_q <= '0;
      gray_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gray_q     <= gray_d;
      drop_cnt_q <= drop_cnt_d;
      gray_err_q <= gray_err_d;
    end
  end

  ro_fifo #(
    .DATA_W (EV_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk_master),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wword),
    .full  (fifo_full),
    .empty (fifo_empty),
    .rdata (ev_data)
  );

  assign ev_valid = !fifo_empty;
  assign drop_cnt = drop_cnt_q;
  assign gray_err = gray_err_q;

endmodule

// File: tb/tb_ro_capture.sv
// Directed bench for ro_capture: stimulus queues expected words, a monitor pops
// and compares them whenever the DUT hands a word over.
module tb_ro_capture;

  logic        clk_master = 1'b0;
  logic        rst, en, bus_eve, bus_pol_eve, ev_ready;
  logic [18:0] gray;
  logic        ev_valid;
  logic [5:0]  ev_data;
  logic [7:0]  drop_cnt;
  logic        gray_err;

  logic [5:0]  exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk_master = ~clk_master;

  ro_capture #(.NCORE(19), .DEPTH(8)) dut (
    .clk_master  (clk_master),
    .rst         (rst),
    .en          (en),
    .gray        (gray),
    .bus_eve     (bus_eve),
    .bus_pol_eve (bus_pol_eve),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_data     (ev_data),
    .drop_cnt    (drop_cnt),
    .gray_err    (gray_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every accepted word must match the oldest expected word.
  always @(negedge clk_master) begin
    if (!rst && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_word: got 0x%0h, expected no word", ev_data);
      end else begin
        check("fifo_order", {26'd0, ev_data}, {26'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk_master);
    #1;
  endtask

  task automatic slot(input logic [18:0] g, input logic eve, input logic pol,
                      input bit exp_push, input int id);
    logic [4:0] id5;
    id5 = 5'(id);
    gray = g; bus_eve = eve; bus_pol_eve = pol;
    if (exp_push) exp_q.push_back({id5, pol});
    tick();
    bus_eve = 1'b0; bus_pol_eve = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          bits [10] = '{0, 1, 2, 3, 7, 8, 9, 10, 11, 12};
    logic [18:0] g;
    logic        p;

    rst = 1'b1; en = 1'b0; gray = '0; bus_eve = 1'b0; bus_pol_eve = 1'b0; ev_ready = 1'b1;
    tick(); tick();
    @(negedge clk_master);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ev_data", ev_data, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_gray_err", gray_err, 0);

    // Bring-up: IDLE -> PRIME -> RUN, then a single event on core 0.
    tick();
    rst = 1'b0; en = 1'b1;
    tick(); tick();
    check("prime_no_event", ev_valid, 0);
    slot(19'h00001, 1'b1, 1'b0, 1, 0);
    @(negedge clk_master);
    check("single_ev_valid_latency", ev_valid, 1);

    // Core 6 slot, plus slots that must not push.
    tick();
    slot(19'h00011, 1'b0, 1'b1, 0, 0);
    slot(19'h00010, 1'b0, 1'b0, 0, 0);
    slot(19'h00050, 1'b1, 1'b1, 1, 6);
    slot(19'h00050, 1'b1, 1'b1, 0, 0);
    tick();
    check("core6_drained", exp_q.size(), 0);
    check("no_err_legal", gray_err, 0);

    // Fill: 10 pushes into 8 slots with the consumer stalled.
    ev_ready = 1'b0;
    g = 19'h00050;
    for (int k = 0; k < 10; k++) begin
      g = g ^ (19'd1 << bits[k]);
      p = ~k[0];
      slot(g, 1'b1, p, k < 8, bits[k]);
    end
    check("drop_cnt_full", drop_cnt, 2);
    @(negedge clk_master);
    check("full_head", ev_data, 6'h01);
    tick();
    @(negedge clk_master);
    check("head_stable_stalled", ev_data, 6'h01);

    // Push and pop on the same edge while full.
    tick();
    ev_ready = 1'b1;
    g = g ^ (19'd1 << 13);
    slot(g, 1'b1, 1'b0, 1, 13);
    ev_ready = 1'b0;
    check("drop_cnt_pushpop", drop_cnt, 2);
    @(negedge clk_master);
    check("head_advanced", ev_data, 6'h02);
    tick();
    g = g ^ (19'd1 << 14);
    slot(g, 1'b1, 1'b1, 0, 14);
    check("drop_cnt_still_full", drop_cnt, 3);

    ev_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    check("drain_complete", exp_q.size(), 0);
    @(negedge clk_master);
    check("empty_after_drain", ev_valid, 0);

    // Dropping en keeps queued words.
    tick();
    ev_ready = 1'b0;
    g = g ^ (19'd1 << 15);
    slot(g, 1'b1, 1'b1, 1, 15);
    en = 1'b0;
    tick(); tick();
    check("no_flush_en_low", ev_valid, 1);
    gray = 19'h00003;
    ev_ready = 1'b1;
    tick(); tick();
    check("drained_en_low", exp_q.size(), 0);

    // Illegal transition 0x003 -> 0x000.
    en = 1'b1;
    tick(); tick();
    slot(19'h00000, 1'b1, 1'b1, 0, 0);
    check("gray_err_set", gray_err, 1);
    @(negedge clk_master);
    check("illegal_no_push", ev_valid, 0);
    tick();
    slot(19'h00001, 1'b1, 1'b0, 1, 0);
    check("gray_err_sticky1", gray_err, 1);
    slot(19'h00003, 1'b0, 1'b0, 0, 0);
    check("gray_err_sticky2", gray_err, 1);
    tick();
    check("legal_after_err_drained", exp_q.size(), 0);

    // Reset with three words queued.
    ev_ready = 1'b0;
    slot(19'h00007, 1'b1, 1'b1, 1, 2);
    slot(19'h0000F, 1'b1, 1'b0, 1, 3);
    slot(19'h0001F, 1'b1, 1'b1, 1, 4);
    rst = 1'b1; gray = 19'h00020; bus_eve = 1'b1; bus_pol_eve = 1'b1;
    tick();
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk_master);
    check("midrst_ev_valid", ev_valid, 0);
    check("midrst_drop_cnt", drop_cnt, 0);
    check("midrst_gray_err", gray_err, 0);
    tick(); tick(); tick();
    check("no_stale_event", ev_valid, 0);
    bus_eve = 1'b0; bus_pol_eve = 1'b0;

    ev_ready = 1'b1;
    slot(19'h00021, 1'b1, 1'b1, 1, 0);
    tick(); tick();
    check("post_reset_event", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
